// File: rtl/stream_check_harness.sv
// Plays a preloaded stimulus vector into a stream DUT and checks the DUT's
// output stream in order against a preloaded expected vector.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no run since reset; waiting for start
// S_DRIVE | presenting stim[0..len-1] one beat per cycle, monitor active
// S_WAIT  | stimulus finished; monitor active, idle timer running
// S_DONE  | run finished; status held until next accepted start or rst

module stream_check_harness #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 256,
    parameter int AW      = $clog2(DEPTH),
    parameter int LW      = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic [LW-1:0]     len,
    input  logic              start,
    output logic [DATA_W-1:0] drv_data,
    output logic              drv_valid,
    input  logic [DATA_W-1:0] mon_data,
    input  logic              mon_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [LW-1:0]     err_cnt,
    output logic [AW-1:0]     first_err,
    output logic              timeout,
    output logic              overflow,
    output logic              len_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] stim_mem [DEPTH];
    logic [DATA_W-1:0] exp_mem  [DEPTH];

    logic [LW-1:0]     len_q, len_q_nxt;
    logic [LW-1:0]     tx_idx, tx_nxt;
    logic [LW-1:0]     rx_idx, rx_nxt;
    logic [LW-1:0]     err_cnt_nxt;
    logic [AW-1:0]     first_err_nxt;
    logic [TW-1:0]     idle_cnt, idle_nxt;
    logic [DATA_W-1:0] drv_data_nxt;
    logic              drv_valid_nxt, pass_nxt, timeout_nxt, overflow_nxt, len_err_nxt;

    // Vector memories are frozen while a run is using them.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            if (cfg_sel)
                exp_mem[cfg_addr] <= cfg_wdata;
            else
                stim_mem[cfg_addr] <= cfg_wdata;
        end
    end

    assign busy = (state == S_DRIVE) || (state == S_WAIT);
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt     = state;
        len_q_nxt     = len_q;
        tx_nxt        = tx_idx;
        rx_nxt        = rx_idx;
        err_cnt_nxt   = err_cnt;
        first_err_nxt = first_err;
        idle_nxt      = idle_cnt;
        drv_data_nxt  = drv_data;
        drv_valid_nxt = drv_valid;
        pass_nxt      = pass;
        timeout_nxt   = timeout;
        overflow_nxt  = overflow;
        len_err_nxt   = len_err;

        if (busy && mon_valid) begin
            if (rx_idx == len_q) begin
                overflow_nxt = 1'b1;
            end else begin
                if (mon_data != exp_mem[rx_idx[AW-1:0]]) begin
                    err_cnt_nxt = err_cnt + 1'b1;
                    if (err_cnt == '0)
                        first_err_nxt = rx_idx[AW-1:0];
                end
                rx_nxt = rx_idx + 1'b1;
            end
        end

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    tx_nxt        = '0;
                    rx_nxt        = '0;
                    err_cnt_nxt   = '0;
                    first_err_nxt = '0;
                    idle_nxt      = '0;
                    timeout_nxt   = 1'b0;
                    overflow_nxt  = 1'b0;
                    len_err_nxt   = 1'b0;
                    pass_nxt      = 1'b0;
                    if (len == '0) begin
                        len_q_nxt = '0;
                        pass_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else if (len > LW'(DEPTH)) begin
                        len_err_nxt = 1'b1;
                        state_nxt   = S_DONE;
                    end else begin
                        len_q_nxt     = len;
                        tx_nxt        = LW'(1);
                        drv_valid_nxt = 1'b1;
                        drv_data_nxt  = stim_mem[0];
                        state_nxt     = S_DRIVE;
                    end
                end
            end
            S_DRIVE: begin
                idle_nxt = '0;
                if (tx_idx == len_q) begin
                    drv_valid_nxt = 1'b0;
                    drv_data_nxt  = '0;
                    state_nxt     = S_WAIT;
                end else begin
                    drv_data_nxt = stim_mem[tx_idx[AW-1:0]];
                    tx_nxt       = tx_idx + 1'b1;
                end
            end
            S_WAIT: begin
                if (rx_nxt == len_q) begin
                    state_nxt = S_DONE;
                end else if (mon_valid) begin
                    idle_nxt = '0;
                end else if (idle_cnt == TW'(TIMEOUT)) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_DONE;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
                if (state_nxt == S_DONE)
                    pass_nxt = (err_cnt_nxt == '0) && !timeout_nxt && !overflow_nxt
                               && (rx_nxt == len_q);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            tx_idx    <= '0;
            rx_idx    <= '0;
            err_cnt   <= '0;
            first_err <= '0;
            idle_cnt  <= '0;
            drv_data  <= '0;
            drv_valid <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_q_nxt;
            tx_idx    <= tx_nxt;
            rx_idx    <= rx_nxt;
            err_cnt   <= err_cnt_nxt;
            first_err <= first_err_nxt;
            idle_cnt  <= idle_nxt;
            drv_data  <= drv_data_nxt;
            drv_valid <= drv_valid_nxt;
            pass      <= pass_nxt;
            timeout   <= timeout_nxt;
            overflow  <= overflow_nxt;
            len_err   <= len_err_nxt;
        end
    end

endmodule

// File: tb/tb_stream_check_harness.sv
// Directed/randomised bench for stream_check_harness: the "DUT" is a bench
// model that replays beats after a fixed offset, and results come from a rule-level model.

module tb_stream_check_harness;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 16;
    localparam int AW      = 6;
    localparam int LW      = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic              cfg_sel;
    logic [AW-1:0]     cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic [LW-1:0]     len;
    logic              start;
    logic [DATA_W-1:0] drv_data;
    logic              drv_valid;
    logic [DATA_W-1:0] mon_data;
    logic              mon_valid;
    logic              busy, done, pass, timeout, overflow, len_err;
    logic [LW-1:0]     err_cnt;
    logic [AW-1:0]     first_err;

    always #5 clk = ~clk;

    stream_check_harness #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .len(len), .start(start),
        .drv_data(drv_data), .drv_valid(drv_valid),
        .mon_data(mon_data), .mon_valid(mon_valid),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err(first_err),
        .timeout(timeout), .overflow(overflow), .len_err(len_err)
    );

    logic [7:0] stim_m [DEPTH];
    logic [7:0] exp_m  [DEPTH];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic cfg_write(input logic sel, input int addr, input logic [7:0] d);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = AW'(addr);
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // One run: the bench DUT presents beat j after edge off+j (sampled at edge off+j+1),
    // emits nout beats (beats past len carry 'extra'). Edges are counted from the start edge (0).
    task automatic run(input string name, input int len_i, input int off, input int nout,
                       input logic [7:0] extra, input bit poke);
        int exp_err, exp_first, exp_done, nseen, done_c, bad_drv, bad_trk, bad_busy, trk;
        bit exp_to, exp_ovf, exp_pass;

        nseen = (nout < len_i) ? nout : len_i;
        if (nout >= len_i) begin
            exp_to   = 1'b0;
            exp_done = imax(off + len_i, len_i + 1);
        end else begin
            exp_to   = 1'b1;
            exp_done = imax(len_i, (nout > 0) ? off + nout : 0) + TIMEOUT + 1;
        end
        exp_ovf   = (nout > len_i) && (off + len_i + 1 <= exp_done);
        exp_err   = 0;
        exp_first = 0;
        for (int j = 0; j < nseen; j++)
            if (stim_m[j] != exp_m[j]) begin
                if (exp_err == 0) exp_first = j;
                exp_err++;
            end
        exp_pass = (exp_err == 0) && !exp_to && !exp_ovf;

        @(negedge clk);
        len   = LW'(len_i);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        done_c   = -1;
        bad_drv  = 0;
        bad_trk  = 0;
        bad_busy = 0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            cfg_we = 1'b0;
            if (poke && c == 0) begin
                cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = AW'(3); cfg_wdata = ~exp_m[3];
            end
            if (poke && c == 1) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = AW'(2); cfg_wdata = ~stim_m[2];
            end
            if (done === 1'b1) begin
                done_c = c;
                break;
            end
            if (c < len_i) begin
                if (drv_valid !== 1'b1 || drv_data !== stim_m[c]) bad_drv++;
            end else if (drv_valid !== 1'b0 || drv_data !== 8'h00) bad_drv++;
            if (busy !== 1'b1) bad_busy++;
            trk = 0;
            for (int j = 0; j < nseen; j++)
                if (off + j + 1 <= c && stim_m[j] != exp_m[j]) trk++;
            if (err_cnt !== LW'(trk)) bad_trk++;
            if (c >= off && c - off < nout) begin
                mon_valid = 1'b1;
                mon_data  = (c - off < len_i) ? stim_m[c - off] : extra;
            end else begin
                mon_valid = 1'b0;
                mon_data  = 8'h00;
            end
        end
        mon_valid = 1'b0;
        mon_data  = 8'h00;
        cfg_we    = 1'b0;

        check({name, "_done_seen"}, 32'(done_c >= 0), 32'd1);
        check({name, "_done_edge"}, 32'(done_c), 32'(exp_done));
        check({name, "_drv_stream"}, 32'(bad_drv), 32'd0);
        check({name, "_busy_track"}, 32'(bad_busy), 32'd0);
        check({name, "_errcnt_track"}, 32'(bad_trk), 32'd0);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        check({name, "_drv_valid_end"}, 32'(drv_valid), 32'd0);
        check({name, "_pass"}, 32'(pass), 32'(exp_pass));
        check({name, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        check({name, "_first_err"}, 32'(first_err), 32'(exp_first));
        check({name, "_timeout"}, 32'(timeout), 32'(exp_to));
        check({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        check({name, "_len_err"}, 32'(len_err), 32'd0);
        @(posedge clk);
        #1;
        check({name, "_done_hold"}, 32'(done), 32'd1);
        check({name, "_pass_hold"}, 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        int hits, rlen, roff, ridx;
        logic [7:0] b;

        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        len = '0; start = 1'b0; mon_data = '0; mon_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_drv_data", 32'(drv_data), 32'd0);
        check("rst_drv_valid", 32'(drv_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_first_err", 32'(first_err), 32'd0);
        check("rst_flags", 32'({timeout, overflow, len_err}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            stim_m[i] = b;
            exp_m[i]  = b;
            cfg_write(1'b0, i, b);
            cfg_write(1'b1, i, b);
        end

        run("loop42", 42, 3, 42, 8'h00, 1'b0);

        exp_m[5]  = exp_m[5] ^ 8'h01;
        exp_m[41] = exp_m[41] ^ 8'h5A;
        cfg_write(1'b1, 5, exp_m[5]);
        cfg_write(1'b1, 41, exp_m[41]);
        run("mism42", 42, 3, 42, 8'h00, 1'b0);
        exp_m[5]  = stim_m[5];
        exp_m[41] = stim_m[41];
        cfg_write(1'b1, 5, exp_m[5]);
        cfg_write(1'b1, 41, exp_m[41]);

        run("tmo", 12, 3, 10, 8'h00, 1'b0);
        run("ovf", 42, 0, 43, 8'hC3, 1'b0);
        run("full64", 64, 3, 64, 8'h00, 1'b0);

        rlen = $urandom_range(1, DEPTH);
        roff = $urandom_range(0, 6);
        ridx = $urandom_range(0, rlen - 1);
        exp_m[ridx] = exp_m[ridx] ^ 8'(1 << $urandom_range(0, 7));
        cfg_write(1'b1, ridx, exp_m[ridx]);
        run("rand", rlen, roff, rlen, 8'h00, 1'b0);
        exp_m[ridx] = stim_m[ridx];
        cfg_write(1'b1, ridx, exp_m[ridx]);

        @(negedge clk);
        len = LW'(65); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("len65_done", 32'(done), 32'd1);
        check("len65_len_err", 32'(len_err), 32'd1);
        check("len65_pass", 32'(pass), 32'd0);
        hits = (drv_valid === 1'b1) ? 1 : 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (drv_valid !== 1'b0) hits++;
        end
        check("len65_no_drive", 32'(hits), 32'd0);

        @(negedge clk);
        len = '0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_pass", 32'(pass), 32'd1);
        check("len0_len_err", 32'(len_err), 32'd0);
        check("len0_busy", 32'(busy), 32'd0);

        @(negedge clk);
        len = LW'(42); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("rst_mid_beat20", 32'({drv_valid, drv_data}), 32'({1'b1, stim_m[19]}));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_outputs", 32'({drv_data, drv_valid, busy, done, pass, timeout, overflow, len_err}), 32'd0);
        check("rst_mid_counts", 32'({err_cnt, first_err}), 32'd0);

        run("after_rst4", 4, 1, 4, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
